uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Bus-facing controller for the UART receiver.
- Holds the receiver configuration (baud rate, parity enable, stop bit) and applies changes only while the receiver is idle.
- Captures each received byte into a small FIFO and reports status, overrun and an interrupt.
- Sits between the core's memory-mapped peripheral bus and the receiver datapath.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, 2..64
CNT_W, $clog2(DEPTH)+1, width of the FIFO occupancy count

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
req_i  in  1  bus access strobe, one cycle per access
we_i  in  1  1 = write, 0 = read
addr_i  in  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC BAUD
wdata_i  in  32  write data
rdata_o  out  32  read data, registered
ack_o  out  1  access complete, one cycle after req_i
rx_busy_i  in  1  receiver busy (not idle)
rx_valid_i  in  1  receiver byte-valid strobe
rx_data_i  in  8  receiver byte
baudrate_o  out  32  applied baud rate to the receiver
parity_en_o  out  1  applied parity enable
stopbit_o  out  1  applied stop-bit setting
irq_o  out  1  interrupt, level

Behaviour:
- Reset values: rdata_o=0, ack_o=0, baudrate_o=9600, parity_en_o=0, stopbit_o=0, irq_o=0; FIFO empty; overrun=0; irq_en=0; shadows equal applied values; cfg state APPLIED.
- Bus timing: ack_o=1 exactly the cycle after any req_i; rdata_o is valid in that ack cycle and is 0 for writes and unmapped offsets.
- DATA read: returns {24'b0, head byte} and pops the FIFO in the req cycle. Reading DATA when empty returns 0 and changes nothing. DATA writes are ignored.
- STATUS read: bit0 not_empty, bit1 full, bit2 overrun, bit3 cfg_pending, bits[8+CNT_W-1:8] count, all other bits 0. STATUS write: bit2=1 clears overrun (W1C); all other bits ignored.
- CTRL write: bit0 irq_en applies immediately. bit1 parity and bit2 stopbit go to shadow registers. bit3 flush empties the FIFO in the same cycle; overrun is unaffected. CTRL read returns {irq_en, shadow parity, shadow stopbit} in bits 0..2.
- BAUD write: wdata_i goes to the shadow baud register; no value checking. BAUD read returns the shadow value.
- Capture: a rising edge of rx_valid_i (registered previous value 0, current value 1) pushes rx_data_i. A strobe held high for several cycles pushes one byte.
- Push while full with no simultaneous pop: byte is dropped, overrun is set (sticky), count stays DEPTH.
- Push and pop in the same cycle while full: both succeed, count unchanged. Same applies at any level: pop takes the old head, push writes to the tail.
- Flush and push in the same cycle: flush wins; the FIFO ends empty.
- Pointers are log2(DEPTH) bits wide and wrap naturally; count is a separate CNT_W-bit register.
- Config FSM:
  - APPLIED: a write to CTRL (parity/stopbit) or BAUD moves to PENDING.
  - PENDING: in any cycle with rx_busy_i=0, all shadow values are copied to the outputs on the next edge and the FSM returns to APPLIED.
  - A shadow write in the same cycle as the apply is included in that apply and leaves the FSM in APPLIED.
  - A frame in progress is never reconfigured.
- cfg_pending is 1 in PENDING.
- irq_o is registered: irq_en & (not_empty | overrun).
- Reset mid-frame or mid-access: all state returns to reset values immediately; the next access after reset completes normally.

Decomposition:
- Package uart_pkg: address offsets, STATUS/CTRL bit indices, reset baud constant 9600, cfg state enum {CFG_APPLIED, CFG_PENDING}.
- One sub-module uart_rx_fifo: DEPTH-parameterised synchronous FIFO with push/pop/flush inputs, head output, full/empty/count outputs, and same-cycle push+pop when full.
- The controller holds the register file, edge detect, overrun logic and config FSM.

Test Plan:
- Reset then read STATUS, CTRL and BAUD -> STATUS=0, CTRL=0, BAUD=9600; baudrate_o=9600; irq_o=0.
- Push bytes 0x41, 0x42, 0x43 with irq_en=1 -> STATUS count=3 and not_empty=1, irq_o=1; three DATA reads return 0x41, 0x42, 0x43; irq_o=0 afterwards; a fourth read returns 0.
- Push 9 bytes 0x00..0x08 into DEPTH=8 -> full=1, overrun=1, and reads return 0x00..0x07. Then write STATUS=0x4 -> overrun=0.
- With the FIFO full, pop and push 0x55 in the same cycle -> count stays 8, no overrun, and 0x55 is the last byte read.
- Hold rx_busy_i=1 and write BAUD=115200 -> baudrate_o stays 9600 and cfg_pending=1. Drop rx_busy_i -> baudrate_o=115200 on the next edge and cfg_pending=0.
- Hold rx_valid_i high for 5 cycles with data 0xA5 -> exactly one push; then CTRL flush -> count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive controller: register map,
// STATUS/CTRL bit positions, reset baud rate and configuration FSM states.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_BAUD   = 4'hC;

    localparam int unsigned STATUS_NOT_EMPTY   = 0;
    localparam int unsigned STATUS_FULL        = 1;
    localparam int unsigned STATUS_OVERRUN     = 2;
    localparam int unsigned STATUS_CFG_PENDING = 3;
    localparam int unsigned STATUS_COUNT_LSB   = 8;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_PARITY  = 1;
    localparam int unsigned CTRL_STOPBIT = 2;
    localparam int unsigned CTRL_FLUSH   = 3;

    localparam logic [31:0] RESET_BAUD = 32'd9600;

    typedef enum logic {
        CFG_APPLIED,
        CFG_PENDING
    } cfg_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received data. Flush beats push; a pop frees the slot that a
// simultaneous push uses, so push+pop always succeeds even when full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Bus-facing UART receive controller: register file, byte capture FIFO,
// overrun/interrupt status and idle-only application of receiver configuration.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    input  logic        rx_busy_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic [31:0] baudrate_o,
    output logic        parity_en_o,
    output logic        stopbit_o,
    output logic        irq_o
);

    logic              rd_req, wr_req, ctrl_wr, baud_wr, status_wr;
    logic              rx_valid_q, push, pop, flush, drop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              overrun_q, overrun_d, irq_en_q, irq_q, ack_q;
    logic              shadow_par_q, shadow_par_d, shadow_stop_q, shadow_stop_d;
    logic [31:0]       shadow_baud_q, shadow_baud_d, rdata_q, rdata_d;
    logic [31:0]       baud_q;
    logic              par_q, stop_q, apply;
    cfg_state_e        state_q, state_d;

    assign rd_req    = req_i & ~we_i;
    assign wr_req    = req_i & we_i;
    assign ctrl_wr   = wr_req & (addr_i == ADDR_CTRL);
    assign baud_wr   = wr_req & (addr_i == ADDR_BAUD);
    assign status_wr = wr_req & (addr_i == ADDR_STATUS);

    assign push  = rx_valid_i & ~rx_valid_q;
    assign pop   = rd_req & (addr_i == ADDR_DATA) & ~fifo_empty;
    assign flush = ctrl_wr & wdata_i[CTRL_FLUSH];
    // Byte lost only when nothing frees a slot; a flush discards it anyway.
    assign drop  = push & fifo_full & ~pop & ~flush;

    assign overrun_d     = (overrun_q & ~(status_wr & wdata_i[STATUS_OVERRUN])) | drop;
    assign shadow_par_d  = ctrl_wr ? wdata_i[CTRL_PARITY] : shadow_par_q;
    assign shadow_stop_d = ctrl_wr ? wdata_i[CTRL_STOPBIT] : shadow_stop_q;
    assign shadow_baud_d = baud_wr ? wdata_i : shadow_baud_q;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wdata  (rx_data_i),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Apply only while the receiver is idle so no frame is reconfigured mid-way.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        case (state_q)
            CFG_APPLIED: if (ctrl_wr || baud_wr) state_d = CFG_PENDING;
            CFG_PENDING: begin
                if (!rx_busy_i) begin
                    apply   = 1'b1;
                    state_d = CFG_APPLIED;
                end
            end
            default: state_d = CFG_APPLIED;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            case (addr_i)
                ADDR_DATA: if (!fifo_empty) rdata_d[DATA_W-1:0] = fifo_head;
                ADDR_STATUS: begin
                    rdata_d[STATUS_NOT_EMPTY]             = ~fifo_empty;
                    rdata_d[STATUS_FULL]                  = fifo_full;
                    rdata_d[STATUS_OVERRUN]               = overrun_q;
                    rdata_d[STATUS_CFG_PENDING]           = (state_q == CFG_PENDING);
                    rdata_d[STATUS_COUNT_LSB +: CNT_W]    = fifo_count;
                end
                ADDR_CTRL: begin
                    rdata_d[CTRL_IRQ_EN]  = irq_en_q;
                    rdata_d[CTRL_PARITY]  = shadow_par_q;
                    rdata_d[CTRL_STOPBIT] = shadow_stop_q;
                end
                ADDR_BAUD: rdata_d = shadow_baud_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= CFG_APPLIED;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
            shadow_par_q  <= 1'b0;
            shadow_stop_q <= 1'b0;
            shadow_baud_q <= RESET_BAUD;
            par_q         <= 1'b0;
            stop_q        <= 1'b0;
            baud_q        <= RESET_BAUD;
        end else begin
            state_q       <= state_d;
            rx_valid_q    <= rx_valid_i;
            overrun_q     <= overrun_d;
            if (ctrl_wr) irq_en_q <= wdata_i[CTRL_IRQ_EN];
            irq_q         <= irq_en_q & (~fifo_empty | overrun_q);
            ack_q         <= req_i;
            rdata_q       <= rdata_d;
            shadow_par_q  <= shadow_par_d;
            shadow_stop_q <= shadow_stop_d;
            shadow_baud_q <= shadow_baud_d;
            if (apply) begin
                par_q  <= shadow_par_d;
                stop_q <= shadow_stop_d;
                baud_q <= shadow_baud_d;
            end
        end
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign baudrate_o  = baud_q;
    assign parity_en_o = par_q;
    assign stopbit_o   = stop_q;
    assign irq_o       = irq_q;

endmodule
